// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit core slice: bus widths, reset vector and
// loader FSM state encodings.
package cpu8_pkg;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int BASE_ADDR_DEF = 0;   // also the PC reset vector

  typedef logic [2:0] state_t;
  localparam state_t LEN  = 3'd0;
  localparam state_t DATA = 3'd1;
  localparam state_t CSUM = 3'd2;
  localparam state_t RUN  = 3'd3;
  localparam state_t ERR  = 3'd4;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input handshake plus the memory write port driven by the loader.
interface prog_loader_if
  import cpu8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (output in_data, in_valid,
                  input  in_ready, mem_addr, mem_wdata, mem_we);
  modport slave  (input  in_data, in_valid,
                  output in_ready, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/loader_csum.sv
// Running modulo-2^W byte sum with clear/add and a "sum + chk == 0" test.
module loader_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  input  logic [W-1:0] chk,
  output logic         zero
);
  logic [W-1:0] sum;
  logic [W-1:0] tot;

  always_ff @(posedge clk) begin
    if (rst || clr) sum <= '0;
    else if (add)   sum <= sum + din;
  end

  assign tot  = sum + chk;
  assign zero = (tot == '0);
endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length/data/checksum frame, writes the image to
// memory from BASE_ADDR and releases the core only on a good checksum.
module prog_loader
  import cpu8_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            busy,
  output logic            done,
  output logic            error
);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W:0]   count;     // one extra bit so L=0 can hold 2^DATA_W
  logic [DATA_W:0]   len_n;
  logic              loading;
  logic              beat;
  logic              csum_ok;

  assign loading      = (state == LEN) || (state == DATA) || (state == CSUM);
  // start masks ready so a beat coinciding with an abort is never consumed
  assign bus.in_ready = loading && !start;
  assign beat         = bus.in_valid && bus.in_ready;
  assign len_n        = (bus.in_data == '0) ? {1'b1, {DATA_W{1'b0}}}
                                            : {1'b0, bus.in_data};

  assign busy    = loading;
  assign done    = (state == RUN);
  assign error   = (state == ERR);
  assign cpu_rst = (state != RUN);

  loader_csum #(.W(DATA_W)) u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (start || (state == LEN && beat)),
    .add  (state == DATA && beat),
    .din  (bus.in_data),
    .chk  (bus.in_data),
    .zero (csum_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LEN;
      ptr           <= ADDR_W'(BASE_ADDR);
      count         <= '0;
      bus.mem_addr  <= ADDR_W'(BASE_ADDR);
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (start) begin
        state <= LEN;
      end else begin
        case (state)
          LEN: if (beat) begin
            count <= len_n;
            ptr   <= ADDR_W'(BASE_ADDR);
            state <= DATA;
          end
          DATA: if (beat) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= bus.in_data;
            ptr           <= ptr + 1'b1;
            count         <= count - 1'b1;
            if (count == (DATA_W+1)'(1)) state <= CSUM;
          end
          CSUM: if (beat) state <= csum_ok ? RUN : ERR;
          RUN:     state <= RUN;
          ERR:     state <= ERR;
          default: state <= LEN;
        endcase
      end
    end
  end
endmodule
